// File: rtl/mmu_dat_engine.sv
// mmu_dat_engine: 6809 DAT MMU with per-page write protect, fault latch,
// IRQ vector task switch and post-reset identity fill of the DAT array.
//
// Ports:
//   e            clock, one CPU bus cycle per rising edge
//   reset        synchronous, active-high
//   address_cpu  CPU address
//   r_w_cpu      1 = read, 0 = write
//   data_in      CPU write data
//   data_out     register read data, valid when data_oe
//   data_oe      register page read in progress
//   address_mem  translated physical address (combinational)
//   ce_mem       physical address lies in on-board RAM (>= $10000)
//   we_mem       on-board RAM write strobe, suppressed by write protect
//   fault        write-protect fault flag
//   busy         DAT identity fill in progress
module mmu_dat_engine #(
    parameter int PAGE_BITS = 3,
    parameter int PHYS_W    = 21,
    parameter int TASK_BITS = 5
) (
    input  logic              e,
    input  logic              reset,
    input  logic [15:0]       address_cpu,
    input  logic              r_w_cpu,
    input  logic [7:0]        data_in,
    output logic [7:0]        data_out,
    output logic              data_oe,
    output logic [PHYS_W-1:0] address_mem,
    output logic              ce_mem,
    output logic              we_mem,
    output logic              fault,
    output logic              busy
);

    localparam int BANK_W = PHYS_W - 16 + PAGE_BITS;
    localparam int OFF_W  = 16 - PAGE_BITS;
    localparam int IDX_W  = TASK_BITS + PAGE_BITS;
    localparam int N_ENT  = 1 << IDX_W;
    localparam logic [4:0] WIN_BYTES = 5'(1 << (PAGE_BITS + 1));

    typedef enum logic {
        ST_NORMAL,
        ST_IRQ
    } irq_state_t;

    typedef enum logic {
        SEQ_IDLE,
        SEQ_FILL
    } seq_state_t;

    // Each DAT entry is {WP, bank}
    logic [BANK_W:0]      dat [N_ENT];

    logic                 mmu_en;
    logic                 auto_sw;
    logic [TASK_BITS-1:0] task_active;
    logic [TASK_BITS-1:0] task_access;
    logic [TASK_BITS-1:0] irq_task;
    logic [TASK_BITS-1:0] saved_task;
    logic [7:0]           fault_page;
    logic [IDX_W-1:0]     fill_k;

    irq_state_t           irq_state;
    irq_state_t           irq_next;
    seq_state_t           seq_state;
    seq_state_t           seq_next;
    logic [IDX_W-1:0]     fill_k_next;
    logic [TASK_BITS-1:0] task_next;
    logic                 save_en;

    // Bus decode
    logic       io_page;
    logic [7:0] lo;
    logic       wr;
    logic       sel_ctrl;
    logic       sel_task_active;
    logic       sel_task_access;
    logic       sel_status;
    logic       sel_fault_page;
    logic       sel_irq_task;
    logic       sel_restore;
    logic       sel_win;
    logic       win_ok;
    logic       vec_fetch;
    logic       restore;
    logic       ctrl_init;

    assign io_page         = (address_cpu[15:8] == 8'hFF);
    assign lo              = address_cpu[7:0];
    assign wr              = !r_w_cpu;
    assign sel_ctrl        = io_page && (lo == 8'h90);
    assign sel_task_active = io_page && (lo == 8'h91);
    assign sel_task_access = io_page && (lo == 8'h92);
    assign sel_status      = io_page && (lo == 8'h93);
    assign sel_fault_page  = io_page && (lo == 8'h94);
    assign sel_irq_task    = io_page && (lo == 8'h95);
    assign sel_restore     = io_page && (lo == 8'h96);
    assign sel_win         = io_page && (lo[7:4] == 4'hA);
    assign win_ok          = ({1'b0, lo[3:0]} < WIN_BYTES);

    // Vector low-byte fetch: odd address $FFF3..$FFFD, reset vector excluded
    assign vec_fetch = auto_sw && r_w_cpu && io_page
                    && (lo >= 8'hF3) && (lo <= 8'hFD) && lo[0];
    assign restore   = wr && sel_restore;
    assign ctrl_init = wr && sel_ctrl && data_in[0];

    assign busy = (seq_state == SEQ_FILL);

    // DAT window: task TASK_ACCESS, page from address bits [PAGE_BITS:1]
    logic [IDX_W-1:0]  win_idx;
    logic [BANK_W:0]   win_entry;
    logic [14:0]       win_bank;
    logic [14:0]       win_wr_bank;
    logic              win_wr_wp;
    logic [BANK_W:0]   win_wr_entry;
    logic [7:0]        win_rd;

    assign win_idx   = {task_access, address_cpu[PAGE_BITS:1]};
    assign win_entry = dat[win_idx];
    assign win_bank  = 15'(win_entry[BANK_W-1:0]);

    always_comb begin
        win_wr_bank = lo[0] ? {win_bank[14:8], data_in}
                            : {data_in[6:0], win_bank[7:0]};
        win_wr_wp   = lo[0] ? win_entry[BANK_W] : data_in[7];
        win_wr_entry = {win_wr_wp, BANK_W'(win_wr_bank)};
    end

    always_comb begin
        win_rd = 8'h00;
        if (!busy && win_ok) begin
            win_rd = lo[0] ? win_bank[7:0]
                           : {win_entry[BANK_W], win_bank[14:8]};
        end
    end

    // Single DAT write port: the fill owns it while busy
    logic              dat_we;
    logic [IDX_W-1:0]  dat_idx;
    logic [BANK_W:0]   dat_wdata;
    logic [BANK_W:0]   fill_entry;

    assign fill_entry = {1'b0, BANK_W'(fill_k[PAGE_BITS-1:0])};

    always_comb begin
        dat_we    = 1'b0;
        dat_idx   = win_idx;
        dat_wdata = win_wr_entry;
        if (busy) begin
            dat_we    = 1'b1;
            dat_idx   = fill_k;
            dat_wdata = fill_entry;
        end else if (wr && sel_win && win_ok) begin
            dat_we    = 1'b1;
        end
    end

    always_ff @(posedge e) begin
        if (dat_we) begin
            dat[dat_idx] <= dat_wdata;
        end
    end

    // Translation
    logic             mmu_eff;
    logic             translated;
    logic [BANK_W:0]  xl_entry;
    logic             wp_hit;

    assign mmu_eff    = mmu_en && !busy;
    assign translated = mmu_eff && !io_page;
    assign xl_entry   = dat[{task_active, address_cpu[15:OFF_W]}];
    assign wp_hit     = translated && wr && xl_entry[BANK_W];

    always_comb begin
        if (translated) begin
            address_mem = {xl_entry[BANK_W-1:0], address_cpu[OFF_W-1:0]};
        end else begin
            address_mem = PHYS_W'(address_cpu);
        end
    end

    assign ce_mem = |address_mem[PHYS_W-1:16];
    assign we_mem = ce_mem && wr && !wp_hit;

    // Auto task-switch FSM
    always_comb begin
        irq_next  = irq_state;
        task_next = task_active;
        save_en   = 1'b0;
        if (wr && sel_task_active) begin
            task_next = data_in[TASK_BITS-1:0];
        end
        unique case (irq_state)
            ST_NORMAL: begin
                if (vec_fetch) begin
                    irq_next  = ST_IRQ;
                    task_next = irq_task;
                    save_en   = 1'b1;
                end
            end
            ST_IRQ: begin
                if (restore) begin
                    irq_next  = ST_NORMAL;
                    task_next = saved_task;
                end
            end
        endcase
    end

    // Identity-fill sequencer
    always_comb begin
        seq_next    = seq_state;
        fill_k_next = fill_k;
        if (ctrl_init) begin
            seq_next    = SEQ_FILL;
            fill_k_next = '0;
        end else begin
            unique case (seq_state)
                SEQ_IDLE: begin
                    seq_next = SEQ_IDLE;
                end
                SEQ_FILL: begin
                    if (fill_k == '1) begin
                        seq_next = SEQ_IDLE;
                    end else begin
                        fill_k_next = fill_k + 1'b1;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge e) begin
        if (reset) begin
            irq_state   <= ST_NORMAL;
            seq_state   <= SEQ_FILL;
            fill_k      <= '0;
            mmu_en      <= 1'b0;
            auto_sw     <= 1'b0;
            task_active <= '0;
            task_access <= '0;
            irq_task    <= '0;
            saved_task  <= '0;
            fault_page  <= 8'h00;
            fault       <= 1'b0;
        end else begin
            irq_state   <= irq_next;
            seq_state   <= seq_next;
            fill_k      <= fill_k_next;
            task_active <= task_next;
            if (save_en) begin
                saved_task <= task_active;
            end
            if (wr && sel_ctrl) begin
                mmu_en  <= data_in[6];
                auto_sw <= data_in[5];
            end
            if (wr && sel_task_access) begin
                task_access <= data_in[TASK_BITS-1:0];
            end
            if (wr && sel_irq_task) begin
                irq_task <= data_in[TASK_BITS-1:0];
            end
            // A new fault wins over a concurrent STATUS clear
            if (wp_hit) begin
                fault <= 1'b1;
                if (!fault) begin
                    fault_page <= address_cpu[15:8];
                end
            end else if (wr && sel_status) begin
                fault <= 1'b0;
            end
        end
    end

    // Register read mux
    assign data_oe = r_w_cpu && io_page
                  && (((lo >= 8'h90) && (lo <= 8'h96)) || (lo[7:4] == 4'hA));

    always_comb begin
        data_out = 8'h00;
        if (sel_ctrl) begin
            data_out = {1'b0, mmu_en, auto_sw, 5'b0};
        end else if (sel_task_active) begin
            data_out = 8'(task_active);
        end else if (sel_task_access) begin
            data_out = 8'(task_access);
        end else if (sel_status) begin
            data_out = {busy, fault, (irq_state == ST_IRQ), 5'b0};
        end else if (sel_fault_page) begin
            data_out = fault_page;
        end else if (sel_irq_task) begin
            data_out = 8'(irq_task);
        end else if (sel_win) begin
            data_out = win_rd;
        end
    end

endmodule

// File: tb/tb_mmu_dat_engine.sv
// tb_mmu_dat_engine: directed vector bench for mmu_dat_engine
// (default parameters: 8 pages, 21-bit physical, 32 tasks).
module tb_mmu_dat_engine;

    logic        e = 1'b0;
    logic        reset;
    logic [15:0] address_cpu;
    logic        r_w_cpu;
    logic [7:0]  data_in;
    logic [7:0]  data_out;
    logic        data_oe;
    logic [20:0] address_mem;
    logic        ce_mem;
    logic        we_mem;
    logic        fault;
    logic        busy;

    mmu_dat_engine dut (
        .e           (e),
        .reset       (reset),
        .address_cpu (address_cpu),
        .r_w_cpu     (r_w_cpu),
        .data_in     (data_in),
        .data_out    (data_out),
        .data_oe     (data_oe),
        .address_mem (address_mem),
        .ce_mem      (ce_mem),
        .we_mem      (we_mem),
        .fault       (fault),
        .busy        (busy)
    );

    always #5 e = ~e;

    int n_vec = 0;
    int n_err = 0;

    logic [20:0] s_am;
    logic        s_ce, s_we, s_oe, s_flt, s_busy;
    logic [7:0]  s_dout;

    typedef struct {
        logic [15:0] a;
        logic        rw;
        logic [7:0]  d;
        logic [20:0] am;
        logic        ce;
        logic        we;
        logic        oe;
        logic [7:0]  dout;
        logic        flt;
    } vec_t;

    vec_t tv[$];

    // One bus cycle: drive, sample mid-cycle, then cross the rising edge
    task automatic bus(input logic [15:0] a, input logic rw,
                       input logic [7:0] d);
        address_cpu = a;
        r_w_cpu     = rw;
        data_in     = d;
        #1;
        s_am   = address_mem;
        s_ce   = ce_mem;
        s_we   = we_mem;
        s_oe   = data_oe;
        s_dout = data_out;
        s_flt  = fault;
        s_busy = busy;
        @(posedge e);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] got,
                       input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", name, got, exp);
        end
    endtask

    task automatic add(input logic [15:0] a, input logic rw,
                       input logic [7:0] d, input logic [20:0] am,
                       input logic ce, input logic we, input logic oe,
                       input logic [7:0] dout, input logic flt);
        vec_t v;
        v.a = a; v.rw = rw; v.d = d; v.am = am; v.ce = ce;
        v.we = we; v.oe = oe; v.dout = dout; v.flt = flt;
        tv.push_back(v);
    endtask

    // Register page read / write, memory access
    task automatic rr(input logic [15:0] a, input logic [7:0] dout,
                      input logic flt);
        add(a, 1'b1, 8'h00, {5'b0, a}, 1'b0, 1'b0, 1'b1, dout, flt);
    endtask

    task automatic rw(input logic [15:0] a, input logic [7:0] d,
                      input logic flt);
        add(a, 1'b0, d, {5'b0, a}, 1'b0, 1'b0, 1'b0, 8'h00, flt);
    endtask

    task automatic mo(input logic [15:0] a, input logic r, input logic [7:0] d,
                      input logic [20:0] am, input logic ce,
                      input logic we, input logic flt);
        add(a, r, d, am, ce, we, 1'b0, 8'h00, flt);
    endtask

    initial begin
        int n;
        logic all_busy;
        logic [7:0] r1, r2;

        reset       = 1'b1;
        address_cpu = 16'h0000;
        r_w_cpu     = 1'b1;
        data_in     = 8'h00;

        // Post-reset state and table
        rr(16'hFF90, 8'h00, 0);
        rr(16'hFF91, 8'h00, 0);
        rr(16'hFF94, 8'h00, 0);
        rr(16'hFF95, 8'h00, 0);
        rr(16'hFF93, 8'h00, 0);
        rw(16'hFF92, 8'h03, 0);
        rr(16'hFFAA, 8'h00, 0);
        rr(16'hFFAB, 8'h05, 0);
        rr(16'hFFA9, 8'h04, 0);
        rr(16'hFF92, 8'h03, 0);
        rw(16'hFF92, 8'h00, 0);
        rw(16'hFF90, 8'h40, 0);
        rw(16'hFFA3, 8'h40, 0);
        rr(16'hFFA3, 8'h40, 0);
        rr(16'hFF90, 8'h40, 0);
        mo(16'h2123, 1, 8'h00, 21'h080123, 1, 0, 0);
        mo(16'h2123, 0, 8'hAA, 21'h080123, 1, 1, 0);
        mo(16'hFF22, 1, 8'h00, 21'h00FF22, 0, 0, 0);
        mo(16'h0123, 1, 8'h00, 21'h000123, 0, 0, 0);
        mo(16'hE456, 1, 8'h00, 21'h00E456, 0, 0, 0);
        rw(16'hFFAF, 8'h12, 0);
        mo(16'hE456, 1, 8'h00, 21'h024456, 1, 0, 0);
        // Write protect and fault latch
        rw(16'hFFA2, 8'h80, 0);
        rr(16'hFFA2, 8'h80, 0);
        mo(16'h3000, 0, 8'h55, 21'h081000, 1, 0, 0);
        rr(16'hFF93, 8'h40, 1);
        rr(16'hFF94, 8'h30, 1);
        mo(16'h2100, 0, 8'h00, 21'h080100, 1, 0, 1);
        rr(16'hFF94, 8'h30, 1);
        rw(16'hFF93, 8'h00, 1);
        rr(16'hFF93, 8'h00, 0);
        rw(16'hFFA2, 8'h00, 0);
        mo(16'h3000, 0, 8'h55, 21'h081000, 1, 1, 0);
        // Auto task switch
        rw(16'hFF90, 8'h60, 0);
        rw(16'hFF91, 8'h02, 0);
        rw(16'hFF95, 8'h07, 0);
        rw(16'hFF92, 8'h07, 0);
        rw(16'hFFA1, 8'h33, 0);
        rr(16'hFF95, 8'h07, 0);
        mo(16'h0010, 1, 8'h00, 21'h000010, 0, 0, 0);
        mo(16'hFFF8, 1, 8'h00, 21'h00FFF8, 0, 0, 0);
        mo(16'hFFF9, 1, 8'h00, 21'h00FFF9, 0, 0, 0);
        mo(16'h0010, 1, 8'h00, 21'h066010, 1, 0, 0);
        rr(16'hFF91, 8'h07, 0);
        rr(16'hFF93, 8'h20, 0);
        mo(16'hFFF7, 1, 8'h00, 21'h00FFF7, 0, 0, 0);
        rr(16'hFF91, 8'h07, 0);
        rw(16'hFF96, 8'h00, 0);
        rr(16'hFF91, 8'h02, 0);
        rr(16'hFF93, 8'h00, 0);
        mo(16'h0010, 1, 8'h00, 21'h000010, 0, 0, 0);
        mo(16'hFFFE, 1, 8'h00, 21'h00FFFE, 0, 0, 0);
        mo(16'hFFFF, 1, 8'h00, 21'h00FFFF, 0, 0, 0);
        rr(16'hFF91, 8'h02, 0);
        mo(16'hFFF1, 1, 8'h00, 21'h00FFF1, 0, 0, 0);
        rr(16'hFF91, 8'h02, 0);
        rr(16'hFF93, 8'h00, 0);
        rw(16'hFF96, 8'h00, 0);
        rr(16'hFF91, 8'h02, 0);
        mo(16'hFFF3, 1, 8'h00, 21'h00FFF3, 0, 0, 0);
        rr(16'hFF91, 8'h07, 0);
        rw(16'hFF91, 8'h05, 0);
        rr(16'hFF93, 8'h20, 0);
        rr(16'hFF91, 8'h05, 0);
        rw(16'hFF96, 8'h00, 0);
        rr(16'hFF91, 8'h02, 0);
        rr(16'hFF93, 8'h00, 0);

        repeat (2) @(posedge e);
        #1;
        reset = 1'b0;

        // Fill after reset: 256 busy cycles
        bus(16'hFF93, 1'b1, 8'h00);
        chk("status_during_fill", {23'b0, s_oe, s_dout}, {23'b0, 1'b1, 8'h80});
        n = s_busy ? 1 : 0;
        for (int i = 0; i < 300; i++) begin
            bus(16'h0000, 1'b1, 8'h00);
            if (!s_busy) break;
            n++;
        end
        chk("reset_fill_cycles", 32'(n), 32'd256);

        foreach (tv[i]) begin
            bus(tv[i].a, tv[i].rw, tv[i].d);
            n_vec++;
            if (s_am !== tv[i].am || s_ce !== tv[i].ce || s_we !== tv[i].we
                || s_oe !== tv[i].oe || s_flt !== tv[i].flt || s_busy !== 1'b0
                || (tv[i].oe && s_dout !== tv[i].dout)) begin
                n_err++;
                $display("FAIL vec%0d a=%h: got am=%h ce=%b we=%b oe=%b do=%h f=%b bsy=%b, expected am=%h ce=%b we=%b oe=%b do=%h f=%b bsy=0",
                         i, tv[i].a, s_am, s_ce, s_we, s_oe, s_dout, s_flt,
                         s_busy, tv[i].am, tv[i].ce, tv[i].we, tv[i].oe,
                         tv[i].dout, tv[i].flt);
            end
        end

        // Fill restart at k=100, window write ignored while busy
        bus(16'hFF90, 1'b0, 8'h61);
        all_busy = 1'b1;
        for (int i = 0; i < 100; i++) begin
            bus(16'h0000, 1'b1, 8'h00);
            all_busy &= s_busy;
        end
        chk("busy_before_restart", {31'b0, all_busy}, 32'd1);
        n = 0;
        r1 = 8'hxx;
        r2 = 8'hxx;
        for (int i = 0; i < 300; i++) begin
            if (i == 0) bus(16'hFF90, 1'b0, 8'h61);
            else if (i == 1) bus(16'hFF90, 1'b1, 8'h00);
            else if (i == 2) bus(16'hFFA3, 1'b1, 8'h00);
            else if (i == 70) bus(16'hFFA1, 1'b0, 8'h77);
            else bus(16'h0000, 1'b1, 8'h00);
            if (i == 1) r1 = s_dout;
            if (i == 2) r2 = s_dout;
            if (i > 0) begin
                if (!s_busy) break;
                n++;
            end
        end
        chk("restart_fill_cycles", 32'(n), 32'd256);
        chk("ctrl_b0_reads_0", {24'b0, r1}, 32'h60);
        chk("window_read_busy", {24'b0, r2}, 32'h00);
        bus(16'hFFA1, 1'b1, 8'h00);
        chk("window_wr_ignored", {24'b0, s_dout}, 32'h00);
        bus(16'hFFA3, 1'b1, 8'h00);
        chk("refill_identity", {24'b0, s_dout}, 32'h01);

        // Reset while in IRQ
        bus(16'hFFF9, 1'b1, 8'h00);
        bus(16'hFF93, 1'b1, 8'h00);
        chk("in_irq_before_reset", {24'b0, s_dout}, 32'h20);
        reset = 1'b1;
        bus(16'h0000, 1'b1, 8'h00);
        reset = 1'b0;
        bus(16'hFF93, 1'b1, 8'h00);
        chk("status_after_reset", {24'b0, s_dout}, 32'h80);
        bus(16'hFF91, 1'b1, 8'h00);
        chk("task_after_reset", {24'b0, s_dout}, 32'h00);
        bus(16'hFF90, 1'b1, 8'h00);
        chk("ctrl_after_reset", {24'b0, s_dout}, 32'h00);
        for (int i = 0; i < 300; i++) begin
            bus(16'h0000, 1'b1, 8'h00);
            if (!s_busy) break;
        end
        chk("fill_done_after_reset", {31'b0, s_busy}, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
